// File: rtl/sevenseg_pkg.sv
// Shared constants for the seven-segment scanner: active-low gfedcba glyphs for 0..F,
// the blank pattern, and the per-slot phase encoding.
package sevenseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic {
    PH_GAP  = 1'b0,
    PH_SHOW = 1'b1
  } phase_e;

endpackage

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
module hex_seg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_LUT[nib_i];

endmodule

// File: rtl/sevenseg_scan.sv
// Time-multiplexed common-anode driver: one digit per REFRESH_DIV slot, leading dead time,
// frame-wide input snapshot, registered outputs lagging the scan counters by one clock.
module sevenseg_scan
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  input  logic                    blank_lz,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_DEAD = CNT_W'(DEAD_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    first_q;
  logic [4*NUM_DIGITS-1:0] val_q;
  logic [NUM_DIGITS-1:0]   dpm_q;
  logic [NUM_DIGITS-1:0]   en_q;
  logic                    blz_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    tick_q;

  logic                    load;
  logic                    lit;
  phase_e                  phase;
  logic [3:0]              nib;
  logic [6:0]              dec_seg;
  logic [NUM_DIGITS-1:0]   blank_vec;
  logic                    zero_above;

  // Snapshot on the first edge out of reset and on the last clock of every frame.
  assign load  = first_q | ((cnt_q == CNT_LAST) & (idx_q == IDX_LAST));
  assign phase = (cnt_q >= CNT_DEAD) ? PH_SHOW : PH_GAP;
  assign lit   = (phase == PH_SHOW) & en_q[idx_q];
  assign nib   = val_q[{idx_q, 2'b00} +: 4];

  hex_seg_decode u_dec (
    .nib_i (nib),
    .seg_o (dec_seg)
  );

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (cnt_q == CNT_LAST) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A digit is a leading zero only if it and every more significant nibble are zero.
  always_comb begin
    zero_above = 1'b1;
    blank_vec  = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above   = zero_above & (val_q[4*i +: 4] == 4'h0);
      blank_vec[i] = blz_q & zero_above;
    end
  end

  always_comb begin
    an_d  = '1;
    seg_d = SEG_BLANK;
    dp_d  = 1'b1;
    if (lit) begin
      an_d[idx_q] = 1'b0;
      seg_d       = blank_vec[idx_q] ? SEG_BLANK : dec_seg;
      dp_d        = ~dpm_q[idx_q];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      first_q <= 1'b1;
      val_q   <= '0;
      dpm_q   <= '0;
      en_q    <= '0;
      blz_q   <= 1'b0;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
      an_q    <= '1;
      tick_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      first_q <= 1'b0;
      if (load) begin
        val_q <= value;
        dpm_q <= dp_in;
        en_q  <= digit_en;
        blz_q <= blank_lz;
      end
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
      tick_q  <= load;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_scan.sv
// Directed bench for sevenseg_scan with NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2.
module tb_sevenseg_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = 16'h12AF;
  logic [3:0]  dp_in = 4'h0;
  logic [3:0]  digit_en = 4'hF;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_tick;

  int total = 0;
  int bad = 0;
  int ecnt = 0;

  sevenseg_scan #(
    .NUM_DIGITS  (4),
    .REFRESH_DIV (8),
    .DEAD_CYCLES (2)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value      (value),
    .dp_in      (dp_in),
    .digit_en   (digit_en),
    .blank_lz   (blank_lz),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Edges since reset release; edge k drives the slot state cnt=(k-1)%8, idx=((k-1)/8)%4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) ecnt <= 0;
    else        ecnt <= ecnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h (edge %0d)", tag, obs, exp, ecnt);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && ecnt >= 1) begin
      chk("an_onehot", 32'($countones(~an) <= 1), 32'd1);
      if (((ecnt - 1) % 8) < 2) chk("an_gap_off", 32'(an), 32'hF);
    end
  end

  // Checks one 32-edge frame, optionally changes value at clock 12, and presents the
  // next frame's inputs before the loading edge.
  task automatic run_frame(input logic [27:0] segs, input logic [3:0] dps, input logic [3:0] en,
                           input bit tear, input logic [15:0] tear_val,
                           input logic [15:0] nv, input logic [3:0] nen, input logic [3:0] ndp,
                           input logic nblz);
    int c, s;
    logic [3:0] ean;
    for (int j = 1; j <= 32; j++) begin
      @(posedge clk);
      @(negedge clk);
      c = (ecnt - 1) % 8;
      s = ((ecnt - 1) / 8) % 4;
      chk("frame_tick", 32'(frame_tick), 32'((ecnt == 1) || (ecnt % 32 == 0)));
      if (c >= 2 && en[s]) begin
        ean = 4'hF;
        ean[s] = 1'b0;
        chk("an_show", 32'(an), 32'(ean));
        chk("seg_show", 32'(seg), 32'(segs[s*7 +: 7]));
        chk("dp_show", 32'(dp), 32'(dps[s]));
      end else begin
        chk("an_off", 32'(an), 32'hF);
        chk("seg_off", 32'(seg), 32'h7F);
        chk("dp_off", 32'(dp), 32'd1);
      end
      if (tear && j == 12) value = tear_val;
      if (j == 31) begin
        value = nv;
        digit_en = nen;
        dp_in = ndp;
        blank_lz = nblz;
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_seg", 32'(seg), 32'h7F);
    chk("rst_dp", 32'(dp), 32'd1);
    chk("rst_tick", 32'(frame_tick), 32'd0);
    rst_n = 1'b1;

    // 12AF, all digits, no blanking.
    run_frame({7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, 4'hF, 1'b0, 16'h0,
              16'h0070, 4'hF, 4'h0, 1'b1);
    // 0070 with leading-zero blanking, then without.
    run_frame({7'h7F, 7'h7F, 7'h78, 7'h40}, 4'hF, 4'hF, 1'b0, 16'h0,
              16'h0070, 4'hF, 4'h0, 1'b0);
    run_frame({7'h40, 7'h40, 7'h78, 7'h40}, 4'hF, 4'hF, 1'b0, 16'h0,
              16'h1111, 4'hF, 4'h0, 1'b0);
    // Mid-frame change to 2222 must not tear the 1111 frame.
    run_frame({7'h79, 7'h79, 7'h79, 7'h79}, 4'hF, 4'hF, 1'b1, 16'h2222,
              16'h2222, 4'hF, 4'h0, 1'b0);
    run_frame({7'h24, 7'h24, 7'h24, 7'h24}, 4'hF, 4'hF, 1'b0, 16'h0,
              16'h2222, 4'b1010, 4'b0010, 1'b0);
    // Digits 0 and 2 disabled; decimal point only on digit 1.
    run_frame({7'h24, 7'h7F, 7'h24, 7'h7F}, 4'b1101, 4'b1010, 1'b0, 16'h0,
              16'h12AF, 4'hF, 4'h0, 1'b0);

    repeat (20) begin
      @(posedge clk);
      @(negedge clk);
    end
    chk("pre_rst_an", 32'(an), 32'hB);
    chk("pre_rst_seg", 32'(seg), 32'h24);
    rst_n = 1'b0;
    #1;
    chk("async_rst_an", 32'(an), 32'hF);
    chk("async_rst_seg", 32'(seg), 32'h7F);
    chk("async_rst_dp", 32'(dp), 32'd1);
    chk("async_rst_tick", 32'(frame_tick), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame({7'h79, 7'h24, 7'h08, 7'h0E}, 4'hF, 4'hF, 1'b0, 16'h0,
              16'h12AF, 4'hF, 4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sevenseg_scan.md
# sevenseg_scan

Time-multiplexed driver for an N-digit common-anode seven-segment display. It takes a packed hex value, decimal-point mask and per-digit enable mask, and scans them one digit at a time onto a shared active-low segment bus and active-low anode lines. Per-digit dead time suppresses ghosting, and optional leading-zero blanking is supported. Inputs are snapshotted once per frame so a frame never tears. It sits between the datapath/status registers and the board display pins, replacing per-digit static decoders.

## Interface
- NUM_DIGITS, 4, digits scanned; legal range 1..8
- REFRESH_DIV, 100000, clocks per digit slot; must be at least DEAD_CYCLES+1
- DEAD_CYCLES, 16, clocks at the start of each slot with all anodes off; 0 disables the gap
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- value  in  4*NUM_DIGITS  hex nibbles; nibble i is value[4i+3:4i]; digit 0 is least significant
- dp_in  in  NUM_DIGITS  1 = light the decimal point of digit i
- digit_en  in  NUM_DIGITS  1 = digit i participates; 0 = its anode stays off for its whole slot
- blank_lz  in  1  1 = blank leading zero digits
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low
- dp  out  1  decimal point, active-low
- an  out  NUM_DIGITS  anode select, active-low, at most one bit low
- frame_tick  out  1  one-cycle pulse on the clock the shadow registers load

## Operation
- Reset (async) clears cnt=0, idx=0, shadow registers=0, first=1.
- Reset values of the outputs: seg=7'h7F, dp=1, an all ones, frame_tick=0.
- cnt runs 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0 and idx increments. idx wraps from NUM_DIGITS-1 to 0.
- Phase: GAP while cnt<DEAD_CYCLES, SHOW otherwise.
- Shadow load of value, dp_in, digit_en and blank_lz happens on:
  - the first edge after reset release (first=1, then first clears), and
  - every edge where cnt=REFRESH_DIV-1 and idx=NUM_DIGITS-1.
- frame_tick is high for the cycle following each load.
- Input changes between loads have no visible effect.
- Leading-zero blanking: when shadow blank_lz=1, digit i≥1 is blanked if its nibble and every higher nibble are 0. Digit 0 is never blanked.
- SHOW phase, digit idx enabled:
  - an[idx]=0, all other anode bits 1.
  - seg = decoded nibble, or 7'h7F if the digit is blanked.
  - dp = ~dp_in[idx]. The decimal point is still shown on a blanked digit.
- GAP phase, or digit disabled: an all ones, seg=7'h7F, dp=1.
- Decode (active-low, gfedcba), 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.

## Timing
- seg, dp and an are registered. They reflect the cnt/idx/shadow state held before the edge, i.e. they lag the counters by exactly one clock.
- Edge k after reset release drives the phase of cnt=k-1 for slot 0. With DEAD_CYCLES=d, an[0] first goes low after edge d+1.
- Frame period = NUM_DIGITS×REFRESH_DIV clocks. Each enabled digit is lit REFRESH_DIV−DEAD_CYCLES clocks per frame.
- Anode transitions always pass through all-off when DEAD_CYCLES≥1. No two anode bits are ever low together, in any configuration.
- Reset asserted mid-frame forces all outputs to their reset values immediately (asynchronously). The scan restarts at digit 0 with a fresh load.
- Changes to blank_lz, dp_in or digit_en mid-frame take effect at the next load only.

## Structure
- Shared package sevenseg_pkg holds:
  - the 16-entry active-low segment constants,
  - SEG_BLANK = 7'h7F,
  - the GAP/SHOW phase encoding.
- One sub-module, hex_seg_decode: combinational nibble → seg using the package constants. The top holds the counters, shadow registers, blanking logic and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, REFRESH_DIV=8, DEAD_CYCLES=2.

- Reset scan: value=16'h12AF, all enabled, blank_lz=0 → over one 32-clock frame, an walks E,D,B,7 (6 clocks each after a 2-clock gap). seg is 0E, 08, 24, 79 for digits 0..3 respectively.
- Leading zeros: value=16'h0070, blank_lz=1 → digits 3 and 2 show seg 7F, digit 1 shows 78, digit 0 shows 40. With blank_lz=0, digits 3 and 2 show 40.
- Tearing: change value from 16'h1111 to 16'h2222 at clock 12 of a frame → the whole current frame shows 79. The next frame, after frame_tick, shows 24 on all digits.
- Enable/dp: digit_en=4'b1010, dp_in=4'b0010 → an[0] and an[2] are never low. During digit 1 SHOW, dp=0. Otherwise dp=1.
- Reset mid-frame: assert rst_n=0 at clock 20 → an=F, seg=7F, dp=1 in the same cycle. After release, digit 0 lights after edge 3.
- Invariant, checked every cycle: at most one an bit is 0, and an is all ones during each GAP.
